// File: rtl/program_sequencer.sv
// Instruction fetch and sequencing unit: fetches two-word instructions, resolves
// control flow against a hardware return stack and dispatches ALU/LSU work.
module program_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  input  logic              cond_flag,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic              lsu_valid,
  input  logic              lsu_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] operand_out,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  localparam int SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int STACK_SLOTS = 1 << SP_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LSU  = 2'b01;
  localparam logic [1:0] CLS_CTRL = 2'b10;

  localparam logic [1:0] SUB_JMP  = 2'b00;
  localparam logic [1:0] SUB_JC   = 2'b01;
  localparam logic [1:0] SUB_CALL = 2'b10;
  localparam logic [1:0] SUB_RET  = 2'b11;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    DISPATCH,
    FAULT
  } state_t;

  state_t            state;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_top;
  logic [ADDR_W-1:0] stack [STACK_SLOTS];
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;
  logic [1:0]        op_class;
  logic [1:0]        sub;
  logic              push;

  assign op_class = instr_out[DATA_W-1:DATA_W-2];
  assign sub      = instr_out[1:0];
  assign target   = ADDR_W'(operand_out);
  assign pc_next  = pc + ADDR_W'(1);
  assign sp_top   = sp - SP_W'(1);
  assign mem_addr = pc;

  // Gated with rst_n so no request escapes while reset holds the FSM in FETCH_OP.
  assign mem_req  = rst_n && (state == FETCH_OP || state == FETCH_ARG);

  assign push = (state == DISPATCH) && (op_class == CLS_CTRL) &&
                (sub == SUB_CALL) && (sp != SP_FULL);

  always_ff @(posedge clk) begin
    if (push)
      stack[sp] <= pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_OP;
      pc          <= ADDR_W'(RESET_ADDR);
      sp          <= '0;
      instr_out   <= '0;
      operand_out <= '0;
      alu_valid   <= 1'b0;
      lsu_valid   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_valid) begin
            instr_out <= mem_rdata;
            pc        <= pc_next;
            state     <= FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          if (mem_valid) begin
            operand_out <= mem_rdata;
            pc          <= pc_next;
            alu_valid   <= (op_class == CLS_ALU);
            lsu_valid   <= (op_class == CLS_LSU);
            state       <= DISPATCH;
          end
        end
        DISPATCH: begin
          case (op_class)
            CLS_ALU: begin
              if (alu_ready) begin
                alu_valid <= 1'b0;
                state     <= FETCH_OP;
              end
            end
            CLS_LSU: begin
              if (lsu_ready) begin
                lsu_valid <= 1'b0;
                state     <= FETCH_OP;
              end
            end
            CLS_CTRL: begin
              state <= FETCH_OP;
              case (sub)
                SUB_JMP: pc <= target;
                SUB_JC: begin
                  if (cond_flag)
                    pc <= target;
                end
                SUB_CALL: begin
                  if (sp == SP_FULL) begin
                    fault <= 1'b1;
                    state <= FAULT;
                  end else begin
                    sp <= sp + SP_W'(1);
                    pc <= target;
                  end
                end
                SUB_RET: begin
                  if (sp == '0) begin
                    fault <= 1'b1;
                    state <= FAULT;
                  end else begin
                    sp <= sp_top;
                    pc <= stack[sp_top];
                  end
                end
                default: ;
              endcase
            end
            default: state <= FETCH_OP;
          endcase
        end
        FAULT: state <= FAULT;
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: memory model with programmable wait
// states, and a scoreboard of expected ALU/LSU dispatches.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic       cond_flag = 1'b0;
  logic       alu_valid;
  logic       alu_ready = 1'b1;
  logic       lsu_valid;
  logic       lsu_ready = 1'b1;
  logic [7:0] instr_out;
  logic [7:0] operand_out;
  logic [7:0] pc;
  logic       fault;

  logic [7:0] mem [256];
  int         mem_wait = 0;
  int         wcnt = 0;
  int         compared = 0;
  int         mismatched = 0;

  typedef struct {
    bit         is_lsu;
    logic [7:0] instr;
    logic [7:0] operand;
  } exp_t;

  exp_t sb[$];

  program_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .cond_flag(cond_flag),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready), .instr_out(instr_out), .operand_out(operand_out),
    .pc(pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory holds mem_valid low for mem_wait cycles on every requested word.
  assign mem_rdata = mem[mem_addr];
  assign mem_valid = (wcnt >= mem_wait);

  always @(posedge clk) begin
    if (!mem_req || mem_valid) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    alu_ready = 1'b1;
    lsu_ready = 1'b1;
    cond_flag = 1'b0;
    mem_wait  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    step(2);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
  endtask

  // Each accepted dispatch must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && ((alu_valid && alu_ready) || (lsu_valid && lsu_ready))) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL sb_unexpected: observed instr 0x%0h expected no dispatch", instr_out);
      end else begin
        e = sb.pop_front();
        check("sb_kind", {30'd0, alu_valid, lsu_valid}, e.is_lsu ? 32'd1 : 32'd2);
        check("sb_instr", {24'd0, instr_out}, {24'd0, e.instr});
        check("sb_operand", {24'd0, operand_out}, {24'd0, e.operand});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] hops [8];
    hops[0] = 8'h10; hops[1] = 8'h20; hops[2] = 8'h12; hops[3] = 8'h02;
    hops[4] = 8'h30; hops[5] = 8'h40; hops[6] = 8'h50; hops[7] = 8'h60;

    // Reset values and linear ALU/LSU flow.
    do_reset();
    mem[0] = 8'h01; mem[1] = 8'h22; mem[2] = 8'h41; mem[3] = 8'h33;
    check("rst_mem_req", mem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_fault", fault, 0);
    check("rst_valids", {alu_valid, lsu_valid}, 0);
    check("rst_instr", instr_out, 0);
    check("rst_operand", operand_out, 0);
    sb.push_back('{1'b0, 8'h01, 8'h22});
    sb.push_back('{1'b1, 8'h41, 8'h33});
    release_reset();
    check("lin_req_c1", mem_req, 1);
    check("lin_addr_c1", mem_addr, 0);
    step(2);
    check("lin_alu_c3", alu_valid, 1);
    check("lin_lsu_c3", lsu_valid, 0);
    check("lin_instr_c3", instr_out, 8'h01);
    check("lin_operand_c3", operand_out, 8'h22);
    step(3);
    check("lin_lsu_c6", lsu_valid, 1);
    check("lin_alu_c6", alu_valid, 0);
    check("lin_instr_c6", instr_out, 8'h41);
    check("lin_operand_c6", operand_out, 8'h33);
    check("lin_pc_c6", pc, 4);
    step(2);

    // Memory wait states and ALU backpressure: 10 cycles per instruction.
    do_reset();
    mem[0] = 8'h05; mem[1] = 8'h66;
    mem_wait  = 2;
    alu_ready = 1'b0;
    sb.push_back('{1'b0, 8'h05, 8'h66});
    release_reset();
    for (int c = 1; c <= 6; c++) begin
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, (c <= 3) ? 0 : 1);
      check("wait_valid_low", alu_valid, 0);
      step(1);
    end
    for (int c = 7; c <= 9; c++) begin
      check("bp_alu_valid", alu_valid, 1);
      check("bp_instr", instr_out, 8'h05);
      check("bp_operand", operand_out, 8'h66);
      step(1);
    end
    alu_ready = 1'b1;
    check("bp_alu_valid_c10", alu_valid, 1);
    step(1);
    check("bp_alu_done_c11", alu_valid, 0);
    check("bp_next_addr_c11", mem_addr, 2);
    mem_wait = 0;

    // Conditional and unconditional jumps; cond_flag only matters at dispatch.
    do_reset();
    mem[0] = 8'h81; mem[1] = 8'h40;
    mem[2] = 8'h81; mem[3] = 8'h40;
    mem[8'h40] = 8'h80; mem[8'h41] = 8'hF0;
    cond_flag = 1'b1;
    release_reset();
    step(2);
    cond_flag = 1'b0;
    step(1);
    check("jc_not_taken", mem_addr, 2);
    cond_flag = 1'b1;
    step(3);
    check("jc_taken", mem_addr, 8'h40);
    cond_flag = 1'b0;
    step(3);
    check("jmp_target", mem_addr, 8'hF0);

    // Nested call/return, then overflow of the return stack.
    do_reset();
    mem[8'h00] = 8'h82; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h82; mem[8'h11] = 8'h20;
    mem[8'h20] = 8'h83; mem[8'h21] = 8'h00;
    mem[8'h12] = 8'h83; mem[8'h13] = 8'h00;
    mem[8'h02] = 8'h82; mem[8'h03] = 8'h30;
    mem[8'h30] = 8'h82; mem[8'h31] = 8'h40;
    mem[8'h40] = 8'h82; mem[8'h41] = 8'h50;
    mem[8'h50] = 8'h82; mem[8'h51] = 8'h60;
    mem[8'h60] = 8'h82; mem[8'h61] = 8'h70;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step(3);
      check("call_ret_addr", mem_addr, hops[i]);
      check("call_ret_nofault", fault, 0);
    end
    step(3);
    check("ovf_fault", fault, 1);
    check("ovf_mem_req", mem_req, 0);
    check("ovf_pc", pc, 8'h62);
    step(5);
    check("ovf_fault_held", fault, 1);
    check("ovf_pc_held", pc, 8'h62);

    // NOP at the top of memory wraps the pc to zero.
    do_reset();
    mem[8'h00] = 8'h80; mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'h00;
    release_reset();
    step(3);
    check("wrap_fe", mem_addr, 8'hFE);
    step(1);
    check("wrap_ff", mem_addr, 8'hFF);
    step(2);
    check("wrap_zero", mem_addr, 8'h00);
    check("wrap_valids", {alu_valid, lsu_valid}, 0);

    // RET with an empty stack faults until reset.
    do_reset();
    mem[0] = 8'h83; mem[1] = 8'h00;
    release_reset();
    step(3);
    check("empty_ret_fault", fault, 1);
    check("empty_ret_req", mem_req, 0);
    check("empty_ret_pc", pc, 2);
    step(4);
    check("empty_ret_held", fault, 1);
    rst_n = 1'b0;
    #1;
    check("empty_ret_cleared", fault, 0);

    // Asynchronous reset while an ALU dispatch is stalled.
    do_reset();
    mem[0] = 8'h02; mem[1] = 8'h07;
    alu_ready = 1'b0;
    release_reset();
    step(2);
    check("mid_alu_raised", alu_valid, 1);
    step(2);
    check("mid_alu_held", alu_valid, 1);
    check("mid_instr_held", instr_out, 8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", alu_valid, 0);
    check("mid_async_pc", pc, 0);
    check("mid_async_req", mem_req, 0);
    check("mid_async_instr", instr_out, 0);
    alu_ready = 1'b1;
    step(1);
    sb.push_back('{1'b0, 8'h02, 8'h07});
    release_reset();
    check("restart_addr", mem_addr, 0);
    step(2);
    check("restart_alu", alu_valid, 1);
    check("restart_instr", instr_out, 8'h02);
    check("restart_operand", operand_out, 8'h07);
    step(3);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
